// File: rtl/soc_multichannel_timer.sv
// N-channel Avalon-MM interval timer; readdata registered (1 cycle), no backpressure, single combined irq.
// Optional shared tick prescaler at the last address when SOC_TIMER_PRESCALE_EN is defined.
module soc_multichannel_timer #(
    parameter int N_CH           = 4,
    parameter int COUNT_W        = 32,
    parameter int DEFAULT_PERIOD = 49999,
    parameter int PRESCALE_W     = 8,
    parameter int AW             = ((N_CH > 1) ? $clog2(N_CH) : 0) + 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic          irq
);
    localparam logic [31:0]        DEF_FULL = 32'(DEFAULT_PERIOD);
    localparam logic [COUNT_W-1:0] DEF_CNT  = DEF_FULL[COUNT_W-1:0];

    logic [COUNT_W-1:0] cnt_q    [N_CH];
    logic [COUNT_W-1:0] cnt_d    [N_CH];
    logic [COUNT_W-1:0] period_q [N_CH];
    logic [COUNT_W-1:0] period_d [N_CH];
    logic [COUNT_W-1:0] snap_q   [N_CH];
    logic [COUNT_W-1:0] snap_d   [N_CH];
    logic [N_CH-1:0]    run_q, run_d, to_q, to_d;
    logic [N_CH-1:0]    cont_q, cont_d, ito_q, ito_d;
    logic [N_CH-1:0]    reload_q, reload_d;
    logic [N_CH-1:0]    wr_ch;
    logic [AW-1:0]      ch_sel;
    logic [1:0]         reg_sel;
    logic [31:0]        readdata_d;
    logic [31:0]        pre_rd;
    logic               wr_en, pre_hit, tick;
    logic               unused_wdata;

    assign ch_sel       = address >> 2;
    assign reg_sel      = address[1:0];
    assign wr_en        = chipselect & ~write_n & ~pre_hit;
    assign unused_wdata = ^writedata;

`ifdef SOC_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q, pcnt_q;

    assign pre_hit = &address;
    assign tick    = (pcnt_q == prescale_q);
    assign pre_rd  = 32'(prescale_q);

    // A prescale write restarts the divider so the new ratio applies from a clean phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else if (chipselect && !write_n && pre_hit) begin
            prescale_q <= writedata[PRESCALE_W-1:0];
            pcnt_q     <= '0;
        end else if (tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + PRESCALE_W'(1);
        end
    end
`else
    assign pre_hit = 1'b0;
    assign tick    = 1'b1;
    assign pre_rd  = '0;
`endif

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_ch[i] = wr_en && (ch_sel == AW'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]    = cnt_q[i];
            period_d[i] = period_q[i];
            snap_d[i]   = snap_q[i];
            run_d[i]    = run_q[i];
            to_d[i]     = to_q[i];
            cont_d[i]   = cont_q[i];
            ito_d[i]    = ito_q[i];
            reload_d[i] = 1'b0;
            if (run_q[i] && tick) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - COUNT_W'(1);
                end else begin
                    cnt_d[i] = period_q[i];
                    to_d[i]  = 1'b1;
                    run_d[i] = cont_q[i];
                end
            end
            // Register writes follow counting so a TO clear or STOP overrides a same-cycle timeout.
            if (wr_ch[i]) begin
                case (reg_sel)
                    2'd0: to_d[i] = 1'b0;
                    2'd1: begin
                        cont_d[i] = writedata[1];
                        ito_d[i]  = writedata[0];
                        if (writedata[2])      run_d[i] = 1'b1;
                        else if (writedata[3]) run_d[i] = 1'b0;
                    end
                    2'd2: begin
                        period_d[i] = writedata[COUNT_W-1:0];
                        reload_d[i] = 1'b1;
                    end
                    default: snap_d[i] = cnt_q[i];
                endcase
            end
            // Delayed reload from a PERIOD write beats everything, including START.
            if (reload_q[i]) begin
                cnt_d[i] = period_q[i];
                run_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        readdata_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == AW'(i)) begin
                case (reg_sel)
                    2'd0:    readdata_d = {30'b0, run_q[i], to_q[i]};
                    2'd1:    readdata_d = {30'b0, cont_q[i], ito_q[i]};
                    2'd2:    readdata_d = 32'(period_q[i]);
                    default: readdata_d = 32'(snap_q[i]);
                endcase
            end
        end
        if (pre_hit) readdata_d = pre_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= DEF_CNT;
                period_q[i] <= DEF_CNT;
                snap_q[i]   <= '0;
            end
            run_q    <= '0;
            to_q     <= '0;
            cont_q   <= '0;
            ito_q    <= '0;
            reload_q <= '0;
            readdata <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            run_q    <= run_d;
            to_q     <= to_d;
            cont_q   <= cont_d;
            ito_q    <= ito_d;
            reload_q <= reload_d;
            readdata <= readdata_d;
        end
    end

    assign irq = |(to_q & ito_q);

endmodule
